// File: rtl/rob_if.sv
// Signal bundle between the reorder buffer and its neighbours: decoder issue/query, CDB, RF update ports, LSB store commit and flush.
// The ROB connects through the slave modport; the decoder/CDB/RF side connects through master.
interface rob_if #(
    parameter int ROB_SIZE_BIT = 3
);
    logic                    issue_valid;
    logic [1:0]              issue_type;
    logic [4:0]              issue_rd;
    logic                    issue_ready;
    logic [31:0]             issue_val;
    logic                    issue_pred_taken;
    logic [31:0]             issue_alt_pc;
    logic [ROB_SIZE_BIT-1:0] issue_id;
    logic                    rob_full;

    logic                    cdb_valid;
    logic [ROB_SIZE_BIT-1:0] cdb_id;
    logic [31:0]             cdb_val;
    logic                    cdb_taken;

    logic [ROB_SIZE_BIT-1:0] qry1_id;
    logic [ROB_SIZE_BIT-1:0] qry2_id;
    logic                    qry1_ready;
    logic                    qry2_ready;
    logic [31:0]             qry1_val;
    logic [31:0]             qry2_val;

    logic                    rf_upd_dep_en;
    logic [4:0]              rf_upd_dep_id;
    logic [ROB_SIZE_BIT-1:0] rf_upd_dep;
    logic                    rf_upd_val_en;
    logic [4:0]              rf_upd_val_id;
    logic [ROB_SIZE_BIT-1:0] rf_upd_val_dep;
    logic [31:0]             rf_upd_val;

    logic                    store_commit_en;
    logic [ROB_SIZE_BIT-1:0] store_commit_id;
    logic                    rob_clear;
    logic [31:0]             clear_pc;

    modport master (
        output issue_valid, issue_type, issue_rd, issue_ready, issue_val, issue_pred_taken, issue_alt_pc,
        output cdb_valid, cdb_id, cdb_val, cdb_taken, qry1_id, qry2_id,
        input  issue_id, rob_full, qry1_ready, qry2_ready, qry1_val, qry2_val,
        input  rf_upd_dep_en, rf_upd_dep_id, rf_upd_dep, rf_upd_val_en, rf_upd_val_id, rf_upd_val_dep, rf_upd_val,
        input  store_commit_en, store_commit_id, rob_clear, clear_pc
    );

    modport slave (
        input  issue_valid, issue_type, issue_rd, issue_ready, issue_val, issue_pred_taken, issue_alt_pc,
        input  cdb_valid, cdb_id, cdb_val, cdb_taken, qry1_id, qry2_id,
        output issue_id, rob_full, qry1_ready, qry2_ready, qry1_val, qry2_val,
        output rf_upd_dep_en, rf_upd_dep_id, rf_upd_dep, rf_upd_val_en, rf_upd_val_id, rf_upd_val_dep, rf_upd_val,
        output store_commit_en, store_commit_id, rob_clear, clear_pc
    );
endinterface

// File: rtl/rob.sv
// Reorder buffer: in-order allocate, out-of-order CDB completion, one in-order commit per cycle; issue stalls on full (registered count).
// Mispredicted branch/jump commits raise a one-cycle flush the next cycle. Define ROB_COMMIT_TRACE_EN for a per-commit trace.
module rob #(
    parameter int ROB_SIZE_BIT = 3
) (
    input  logic  clk_in,
    input  logic  rst_in,
    input  logic  rdy_in,
    rob_if.slave  bus
);
    localparam int ROB_SIZE = 1 << ROB_SIZE_BIT;
    localparam logic [ROB_SIZE_BIT:0] FULL_COUNT = {1'b1, {ROB_SIZE_BIT{1'b0}}};
    localparam logic [ROB_SIZE_BIT:0] CNT_ONE    = {{ROB_SIZE_BIT{1'b0}}, 1'b1};
    localparam logic [1:0] T_REG    = 2'd0;
    localparam logic [1:0] T_STORE  = 2'd1;
    localparam logic [1:0] T_JUMP   = 2'd3;

    typedef logic [ROB_SIZE_BIT-1:0] idx_t;
    localparam idx_t IDX_ONE = {{(ROB_SIZE_BIT-1){1'b0}}, 1'b1};

    idx_t                  head_q;
    idx_t                  tail_q;
    logic [ROB_SIZE_BIT:0] count_q;
    logic [ROB_SIZE-1:0]   busy_q;
    logic [ROB_SIZE-1:0]   ready_q;
    logic [ROB_SIZE-1:0]   pred_q;
    logic [ROB_SIZE-1:0]   taken_q;
    logic [1:0]            type_q [ROB_SIZE];
    logic [4:0]            rd_q   [ROB_SIZE];
    logic [31:0]           val_q  [ROB_SIZE];
    logic [31:0]           alt_q  [ROB_SIZE];
    logic                  clear_q;
    logic [31:0]           clear_pc_q;

    logic full;
    logic issue_acc;
    logic commit;
    logic head_writes_rd;
    logic mispredict;
    logic q1_hit;
    logic q2_hit;

    assign full           = (count_q == FULL_COUNT);
    assign issue_acc      = ~rst_in & rdy_in & bus.issue_valid & ~full & ~clear_q;
    assign commit         = rdy_in & ~clear_q & busy_q[head_q] & ready_q[head_q];
    assign head_writes_rd = (type_q[head_q] == T_REG) | (type_q[head_q] == T_JUMP);
    // Types 2 and 3 (branch, jump) are exactly the ones with bit 1 set.
    assign mispredict     = commit & type_q[head_q][1] & (taken_q[head_q] != pred_q[head_q]);

    assign bus.rob_full        = full;
    assign bus.issue_id        = tail_q;
    assign bus.rf_upd_dep_en   = issue_acc & ((bus.issue_type == T_REG) | (bus.issue_type == T_JUMP));
    assign bus.rf_upd_dep_id   = bus.issue_rd;
    assign bus.rf_upd_dep      = tail_q;
    assign bus.rf_upd_val_en   = commit & head_writes_rd;
    assign bus.rf_upd_val_id   = rd_q[head_q];
    assign bus.rf_upd_val_dep  = head_q;
    assign bus.rf_upd_val      = val_q[head_q];
    assign bus.store_commit_en = commit & (type_q[head_q] == T_STORE);
    assign bus.store_commit_id = head_q;
    assign bus.rob_clear       = clear_q;
    assign bus.clear_pc        = clear_pc_q;

    // Operand lookup bypasses a result being broadcast this very cycle.
    assign q1_hit         = bus.cdb_valid & (bus.cdb_id == bus.qry1_id);
    assign q2_hit         = bus.cdb_valid & (bus.cdb_id == bus.qry2_id);
    assign bus.qry1_ready = ready_q[bus.qry1_id] | q1_hit;
    assign bus.qry2_ready = ready_q[bus.qry2_id] | q2_hit;
    assign bus.qry1_val   = q1_hit ? bus.cdb_val : val_q[bus.qry1_id];
    assign bus.qry2_val   = q2_hit ? bus.cdb_val : val_q[bus.qry2_id];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            busy_q     <= '0;
            ready_q    <= '0;
            pred_q     <= '0;
            taken_q    <= '0;
            clear_q    <= 1'b0;
            clear_pc_q <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                type_q[i] <= '0;
                rd_q[i]   <= '0;
                val_q[i]  <= '0;
                alt_q[i]  <= '0;
            end
        end else if (rdy_in) begin
            if (clear_q) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
                busy_q  <= '0;
                ready_q <= '0;
                clear_q <= 1'b0;
            end else begin
                if (bus.cdb_valid && busy_q[bus.cdb_id]) begin
                    ready_q[bus.cdb_id] <= 1'b1;
                    val_q[bus.cdb_id]   <= bus.cdb_val;
                    taken_q[bus.cdb_id] <= bus.cdb_taken;
                end
                if (issue_acc) begin
                    busy_q[tail_q]  <= 1'b1;
                    ready_q[tail_q] <= bus.issue_ready;
                    type_q[tail_q]  <= bus.issue_type;
                    rd_q[tail_q]    <= bus.issue_rd;
                    val_q[tail_q]   <= bus.issue_val;
                    pred_q[tail_q]  <= bus.issue_pred_taken;
                    // Entries resolved at issue can never mispredict.
                    taken_q[tail_q] <= bus.issue_pred_taken;
                    alt_q[tail_q]   <= bus.issue_alt_pc;
                    tail_q          <= tail_q + IDX_ONE;
                end
                // Placed after the CDB write so a retiring head is freed even if broadcast again.
                if (commit) begin
                    busy_q[head_q]  <= 1'b0;
                    ready_q[head_q] <= 1'b0;
                    head_q          <= head_q + IDX_ONE;
                end
                case ({issue_acc, commit})
                    2'b10:   count_q <= count_q + CNT_ONE;
                    2'b01:   count_q <= count_q - CNT_ONE;
                    default: count_q <= count_q;
                endcase
                clear_q <= mispredict;
                if (mispredict) clear_pc_q <= alt_q[head_q];
            end
        end
    end

`ifdef ROB_COMMIT_TRACE_EN
    logic [31:0] cycle_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) cycle_q <= '0;
        else        cycle_q <= cycle_q + 32'd1;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && commit)
            $display("rob commit: cycle=%0d id=%0d type=%0d rd=%0d val=%08h mispredict=%0b",
                     cycle_q, head_q, type_q[head_q], rd_q[head_q], val_q[head_q], mispredict);
    end
`endif
endmodule

// File: tb/tb_rob.sv
// Directed scenarios plus a randomized run checked against a queue-based program-order model of the reorder buffer.
module tb_rob;
    localparam int RSB = 3;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic rdy_in = 1'b1;
    int   errors = 0;
    int   checks = 0;

    rob_if #(.ROB_SIZE_BIT(RSB)) bus ();
    rob #(.ROB_SIZE_BIT(RSB)) dut (.clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .bus(bus));

    always #5 clk_in = ~clk_in;

    typedef struct {
        int          id;
        logic [1:0]  t;
        logic [4:0]  rd;
        logic [31:0] v;
        bit          rdy;
        bit          pred;
        bit          tk;
        logic [31:0] alt;
    } ent_t;

    task automatic idle();
        rdy_in = 1'b1;
        bus.issue_valid = 1'b0; bus.issue_type = 2'd0; bus.issue_rd = 5'd0; bus.issue_ready = 1'b0;
        bus.issue_val = 32'd0; bus.issue_pred_taken = 1'b0; bus.issue_alt_pc = 32'd0;
        bus.cdb_valid = 1'b0; bus.cdb_id = '0; bus.cdb_val = 32'd0; bus.cdb_taken = 1'b0;
        bus.qry1_id = '0; bus.qry2_id = '0;
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic rdy, input logic [31:0] v,
                         input logic pred, input logic [31:0] alt);
        bus.issue_valid = 1'b1; bus.issue_type = t; bus.issue_rd = rd; bus.issue_ready = rdy;
        bus.issue_val = v; bus.issue_pred_taken = pred; bus.issue_alt_pc = alt;
    endtask

    task automatic cdb(input logic [RSB-1:0] id, input logic [31:0] v, input logic tk);
        bus.cdb_valid = 1'b1; bus.cdb_id = id; bus.cdb_val = v; bus.cdb_taken = tk;
    endtask

    task automatic do_reset();
        idle();
        rst_in = 1'b1;
        cyc();
        rst_in = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_in = 1'b1;
        #2;
        checks++; if (bus.rob_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.rob_full); end
        checks++; if (bus.issue_id !== 3'd0) begin errors++; $display("FAIL reset_issue_id: got %0d want 0", bus.issue_id); end
        checks++; if (bus.rob_clear !== 1'b0) begin errors++; $display("FAIL reset_clear: got %b want 0", bus.rob_clear); end
        checks++; if (bus.clear_pc !== 32'd0) begin errors++; $display("FAIL reset_clear_pc: got %h want 0", bus.clear_pc); end
        checks++; if (bus.rf_upd_dep_en !== 1'b0) begin errors++; $display("FAIL reset_dep_en: got %b want 0", bus.rf_upd_dep_en); end
        checks++; if (bus.rf_upd_val_en !== 1'b0) begin errors++; $display("FAIL reset_val_en: got %b want 0", bus.rf_upd_val_en); end
        checks++; if (bus.store_commit_en !== 1'b0) begin errors++; $display("FAIL reset_store_en: got %b want 0", bus.store_commit_en); end
        checks++; if (bus.qry1_ready !== 1'b0) begin errors++; $display("FAIL reset_qry_ready: got %b want 0", bus.qry1_ready); end
        cyc();
        rst_in = 1'b0;
        #1;
    endtask

    task automatic test_issue_commit();
        do_reset();
        issue(2'd0, 5'd5, 1'b0, 32'd0, 1'b0, 32'd0);
        #1;
        checks++; if (bus.issue_id !== 3'd0) begin errors++; $display("FAIL ic_issue_id: got %0d want 0", bus.issue_id); end
        checks++; if (bus.rf_upd_dep_en !== 1'b1) begin errors++; $display("FAIL ic_dep_en: got %b want 1", bus.rf_upd_dep_en); end
        checks++; if (bus.rf_upd_dep_id !== 5'd5) begin errors++; $display("FAIL ic_dep_id: got %0d want 5", bus.rf_upd_dep_id); end
        checks++; if (bus.rf_upd_dep !== 3'd0) begin errors++; $display("FAIL ic_dep: got %0d want 0", bus.rf_upd_dep); end
        cyc(); idle(); cdb(3'd0, 32'h1234, 1'b0);
        #1;
        checks++; if (bus.rf_upd_val_en !== 1'b0) begin errors++; $display("FAIL ic_no_bypass: got %b want 0", bus.rf_upd_val_en); end
        cyc(); idle();
        #1;
        checks++; if (bus.rf_upd_val_en !== 1'b1) begin errors++; $display("FAIL ic_val_en: got %b want 1", bus.rf_upd_val_en); end
        checks++; if (bus.rf_upd_val_id !== 5'd5) begin errors++; $display("FAIL ic_val_id: got %0d want 5", bus.rf_upd_val_id); end
        checks++; if (bus.rf_upd_val_dep !== 3'd0) begin errors++; $display("FAIL ic_val_dep: got %0d want 0", bus.rf_upd_val_dep); end
        checks++; if (bus.rf_upd_val !== 32'h1234) begin errors++; $display("FAIL ic_val: got %h want 1234", bus.rf_upd_val); end
        cyc();
        checks++; if (bus.rf_upd_val_en !== 1'b0) begin errors++; $display("FAIL ic_single_commit: got %b want 0", bus.rf_upd_val_en); end
        checks++; if (bus.issue_id !== 3'd1) begin errors++; $display("FAIL ic_tail: got %0d want 1", bus.issue_id); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            issue(2'd0, 5'(i + 1), 1'b0, 32'd0, 1'b0, 32'd0);
            #1;
            checks++; if (bus.rf_upd_dep !== 3'(i)) begin errors++; $display("FAIL fw_dep: got %0d want %0d", bus.rf_upd_dep, i); end
            checks++; if (bus.rob_full !== 1'b0) begin errors++; $display("FAIL fw_not_full: got %b want 0 at %0d", bus.rob_full, i); end
            cyc();
        end
        issue(2'd0, 5'd20, 1'b0, 32'd0, 1'b0, 32'd0);
        #1;
        checks++; if (bus.rob_full !== 1'b1) begin errors++; $display("FAIL fw_full: got %b want 1", bus.rob_full); end
        checks++; if (bus.rf_upd_dep_en !== 1'b0) begin errors++; $display("FAIL fw_9th_dep_en: got %b want 0", bus.rf_upd_dep_en); end
        cyc(); idle(); cdb(3'd0, 32'haa, 1'b0);
        #1;
        checks++; if (bus.issue_id !== 3'd0) begin errors++; $display("FAIL fw_tail_stays: got %0d want 0", bus.issue_id); end
        cyc(); idle();
        #1;
        checks++; if (bus.rf_upd_val_en !== 1'b1) begin errors++; $display("FAIL fw_commit_en: got %b want 1", bus.rf_upd_val_en); end
        checks++; if (bus.rf_upd_val !== 32'haa) begin errors++; $display("FAIL fw_commit_val: got %h want aa", bus.rf_upd_val); end
        checks++; if (bus.rob_full !== 1'b1) begin errors++; $display("FAIL fw_full_during_commit: got %b want 1", bus.rob_full); end
        cyc(); issue(2'd0, 5'd9, 1'b0, 32'd0, 1'b0, 32'd0);
        #1;
        checks++; if (bus.rob_full !== 1'b0) begin errors++; $display("FAIL fw_freed: got %b want 0", bus.rob_full); end
        checks++; if (bus.rf_upd_dep_en !== 1'b1) begin errors++; $display("FAIL fw_wrap_dep_en: got %b want 1", bus.rf_upd_dep_en); end
        checks++; if (bus.rf_upd_dep !== 3'd0) begin errors++; $display("FAIL fw_wrap_dep: got %0d want 0", bus.rf_upd_dep); end
        cyc(); idle();
        #1;
        checks++; if (bus.rob_full !== 1'b1) begin errors++; $display("FAIL fw_refull: got %b want 1", bus.rob_full); end
    endtask

    task automatic test_mispredict();
        do_reset();
        issue(2'd2, 5'd0, 1'b0, 32'd0, 1'b0, 32'h100);
        #1;
        checks++; if (bus.rf_upd_dep_en !== 1'b0) begin errors++; $display("FAIL mp_branch_dep_en: got %b want 0", bus.rf_upd_dep_en); end
        cyc(); issue(2'd0, 5'd3, 1'b0, 32'd0, 1'b0, 32'd0);
        cyc(); idle(); cdb(3'd0, 32'd0, 1'b1);
        cyc(); idle();
        #1;
        checks++; if (bus.rob_clear !== 1'b0) begin errors++; $display("FAIL mp_clear_early: got %b want 0", bus.rob_clear); end
        checks++; if (bus.rf_upd_val_en !== 1'b0) begin errors++; $display("FAIL mp_branch_val_en: got %b want 0", bus.rf_upd_val_en); end
        cyc(); issue(2'd0, 5'd4, 1'b0, 32'd0, 1'b0, 32'd0);
        #1;
        checks++; if (bus.rob_clear !== 1'b1) begin errors++; $display("FAIL mp_clear: got %b want 1", bus.rob_clear); end
        checks++; if (bus.clear_pc !== 32'h100) begin errors++; $display("FAIL mp_clear_pc: got %h want 100", bus.clear_pc); end
        checks++; if (bus.rf_upd_dep_en !== 1'b0) begin errors++; $display("FAIL mp_issue_blocked: got %b want 0", bus.rf_upd_dep_en); end
        cyc(); idle(); cdb(3'd1, 32'h77, 1'b0);
        #1;
        checks++; if (bus.rob_clear !== 1'b0) begin errors++; $display("FAIL mp_clear_one_cycle: got %b want 0", bus.rob_clear); end
        checks++; if (bus.issue_id !== 3'd0) begin errors++; $display("FAIL mp_tail_reset: got %0d want 0", bus.issue_id); end
        cyc(); idle();
        #1;
        checks++; if (bus.rf_upd_val_en !== 1'b0) begin errors++; $display("FAIL mp_young_discarded: got %b want 0", bus.rf_upd_val_en); end
    endtask

    task automatic test_overlap();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            issue(2'd0, 5'(10 + i), 1'b0, 32'd0, 1'b0, 32'd0);
            cyc();
        end
        idle(); cdb(3'd0, 32'h11, 1'b0);
        cyc(); idle();
        issue(2'd0, 5'd8, 1'b0, 32'd0, 1'b0, 32'd0);
        cdb(3'd2, 32'habcd, 1'b0);
        bus.qry1_id = 3'd2; bus.qry2_id = 3'd1;
        #1;
        checks++; if (bus.rf_upd_val_en !== 1'b1) begin errors++; $display("FAIL ov_commit: got %b want 1", bus.rf_upd_val_en); end
        checks++; if (bus.rf_upd_val !== 32'h11) begin errors++; $display("FAIL ov_commit_val: got %h want 11", bus.rf_upd_val); end
        checks++; if (bus.rf_upd_dep !== 3'd3) begin errors++; $display("FAIL ov_issue_dep: got %0d want 3", bus.rf_upd_dep); end
        checks++; if (bus.qry1_ready !== 1'b1) begin errors++; $display("FAIL ov_qry_bypass_ready: got %b want 1", bus.qry1_ready); end
        checks++; if (bus.qry1_val !== 32'habcd) begin errors++; $display("FAIL ov_qry_bypass_val: got %h want abcd", bus.qry1_val); end
        checks++; if (bus.qry2_ready !== 1'b0) begin errors++; $display("FAIL ov_qry_pending: got %b want 0", bus.qry2_ready); end
        cyc(); idle(); bus.qry1_id = 3'd2;
        #1;
        checks++; if (bus.qry1_ready !== 1'b1 || bus.qry1_val !== 32'habcd) begin
            errors++; $display("FAIL ov_qry_stored: got %b/%h want 1/abcd", bus.qry1_ready, bus.qry1_val); end
        // Count is 3 here, so exactly five more issues fill the buffer.
        for (int i = 0; i < 5; i++) begin
            issue(2'd1, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0);
            #1;
            checks++; if (bus.rob_full !== 1'b0) begin errors++; $display("FAIL ov_count_full_early: got %b want 0 at %0d", bus.rob_full, i); end
            cyc();
        end
        idle();
        #1;
        checks++; if (bus.rob_full !== 1'b1) begin errors++; $display("FAIL ov_count_full: got %b want 1", bus.rob_full); end
    endtask

    task automatic test_rdy_low();
        do_reset();
        issue(2'd0, 5'd7, 1'b1, 32'd55, 1'b0, 32'd0);
        cyc(); idle();
        rdy_in = 1'b0;
        issue(2'd0, 5'd8, 1'b0, 32'd0, 1'b0, 32'd0);
        #1;
        checks++; if (bus.rf_upd_val_en !== 1'b0) begin errors++; $display("FAIL rl_val_en: got %b want 0", bus.rf_upd_val_en); end
        checks++; if (bus.rf_upd_dep_en !== 1'b0) begin errors++; $display("FAIL rl_dep_en: got %b want 0", bus.rf_upd_dep_en); end
        cyc(); cyc();
        checks++; if (bus.issue_id !== 3'd1) begin errors++; $display("FAIL rl_tail_frozen: got %0d want 1", bus.issue_id); end
        idle();
        #1;
        checks++; if (bus.rf_upd_val_en !== 1'b1 || bus.rf_upd_val_dep !== 3'd0 || bus.rf_upd_val !== 32'd55) begin
            errors++; $display("FAIL rl_head_kept: got %b/%0d/%0d want 1/0/55", bus.rf_upd_val_en, bus.rf_upd_val_dep, bus.rf_upd_val); end
        cyc();
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue(2'd3, 5'd2, 1'b0, 32'd0, 1'b0, 32'h200);
        cyc(); idle(); cdb(3'd0, 32'h44, 1'b1);
        cyc(); idle();
        #1;
        checks++; if (bus.rf_upd_val_en !== 1'b1 || bus.rf_upd_val_id !== 5'd2 || bus.rf_upd_val !== 32'h44) begin
            errors++; $display("FAIL rm_jump_commit: got %b/%0d/%h want 1/2/44", bus.rf_upd_val_en, bus.rf_upd_val_id, bus.rf_upd_val); end
        cyc(); rdy_in = 1'b0;
        #1;
        checks++; if (bus.rob_clear !== 1'b1 || bus.clear_pc !== 32'h200) begin
            errors++; $display("FAIL rm_clear: got %b/%h want 1/200", bus.rob_clear, bus.clear_pc); end
        cyc();
        checks++; if (bus.rob_clear !== 1'b1) begin errors++; $display("FAIL rm_clear_held: got %b want 1", bus.rob_clear); end
        rst_in = 1'b1;
        #1;
        checks++; if (bus.rob_clear !== 1'b0 || bus.clear_pc !== 32'd0) begin
            errors++; $display("FAIL rm_async_reset: got %b/%h want 0/0", bus.rob_clear, bus.clear_pc); end
        checks++; if (bus.issue_id !== 3'd0 || bus.rob_full !== 1'b0) begin
            errors++; $display("FAIL rm_reset_ptrs: got %0d/%b want 0/0", bus.issue_id, bus.rob_full); end
        cyc();
        rst_in = 1'b0;
        idle();
        #1;
    endtask

    task automatic test_random();
        ent_t mq[$];
        ent_t e;
        int   m_tail;
        bit   m_clear;
        logic [31:0] m_pc;
        bit   full, acc, com, mis, hit, q1v, q2v, exp_rdy;
        int   k1, k2, pick;
        int   pend[$];
        do_reset();
        m_tail = 0; m_clear = 0; m_pc = 32'd0;
        for (int c = 0; c < 800; c++) begin
            idle();
            rdy_in = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 9) < 6)
                issue(2'($urandom_range(0, 3)), 5'($urandom), ($urandom_range(0, 3) == 0), $urandom, 1'($urandom), $urandom);
            pend.delete();
            foreach (mq[i]) if (!mq[i].rdy) pend.push_back(i);
            if ($urandom_range(0, 1) == 1) begin
                if (pend.size() > 0 && $urandom_range(0, 4) != 0) begin
                    pick = pend[$urandom_range(0, pend.size() - 1)];
                    cdb(3'(mq[pick].id), $urandom, ($urandom_range(0, 4) == 0) ? ~mq[pick].pred : mq[pick].pred);
                end else begin
                    cdb(3'($urandom), $urandom, 1'($urandom));
                end
            end
            q1v = 0; q2v = 0; k1 = 0; k2 = 0;
            if (mq.size() > 0) begin
                k1 = $urandom_range(0, mq.size() - 1); k2 = $urandom_range(0, mq.size() - 1);
                bus.qry1_id = 3'(mq[k1].id); bus.qry2_id = 3'(mq[k2].id); q1v = 1; q2v = 1;
            end
            #1;
            full = (mq.size() == 8);
            acc  = rdy_in && bus.issue_valid && !full && !m_clear;
            com  = 0;
            if (mq.size() > 0) com = rdy_in && !m_clear && mq[0].rdy;
            checks++; if (bus.rob_full !== full) begin errors++; $display("FAIL rnd_full c%0d: got %b want %b", c, bus.rob_full, full); end
            checks++; if (bus.issue_id !== 3'(m_tail)) begin errors++; $display("FAIL rnd_issue_id c%0d: got %0d want %0d", c, bus.issue_id, m_tail); end
            checks++; if (bus.rf_upd_dep_en !== (acc && (bus.issue_type == 2'd0 || bus.issue_type == 2'd3))) begin
                errors++; $display("FAIL rnd_dep_en c%0d: got %b want %b", c, bus.rf_upd_dep_en, !bus.rf_upd_dep_en); end
            if (acc) begin
                checks++; if (bus.rf_upd_dep !== 3'(m_tail)) begin errors++; $display("FAIL rnd_dep c%0d: got %0d want %0d", c, bus.rf_upd_dep, m_tail); end
            end
            checks++; if (bus.rf_upd_val_en !== (com && (mq[0].t == 2'd0 || mq[0].t == 2'd3))) begin
                errors++; $display("FAIL rnd_val_en c%0d: got %b want %b", c, bus.rf_upd_val_en, !bus.rf_upd_val_en); end
            checks++; if (bus.store_commit_en !== (com && mq[0].t == 2'd1)) begin
                errors++; $display("FAIL rnd_store_en c%0d: got %b want %b", c, bus.store_commit_en, !bus.store_commit_en); end
            if (com) begin
                checks++; if (bus.rf_upd_val_dep !== 3'(mq[0].id) || bus.rf_upd_val_id !== mq[0].rd || bus.rf_upd_val !== mq[0].v) begin
                    errors++; $display("FAIL rnd_commit c%0d: got %0d/%0d/%h want %0d/%0d/%h", c, bus.rf_upd_val_dep, bus.rf_upd_val_id,
                                       bus.rf_upd_val, mq[0].id, mq[0].rd, mq[0].v); end
            end
            checks++; if (bus.rob_clear !== m_clear) begin errors++; $display("FAIL rnd_clear c%0d: got %b want %b", c, bus.rob_clear, m_clear); end
            if (m_clear) begin
                checks++; if (bus.clear_pc !== m_pc) begin errors++; $display("FAIL rnd_clear_pc c%0d: got %h want %h", c, bus.clear_pc, m_pc); end
            end
            if (q1v) begin
                hit = bus.cdb_valid && (bus.cdb_id == 3'(mq[k1].id));
                exp_rdy = mq[k1].rdy || hit;
                checks++; if (bus.qry1_ready !== exp_rdy || (exp_rdy && bus.qry1_val !== (hit ? bus.cdb_val : mq[k1].v))) begin
                    errors++; $display("FAIL rnd_qry1 c%0d: got %b/%h want %b", c, bus.qry1_ready, bus.qry1_val, exp_rdy); end
            end
            if (q2v) begin
                hit = bus.cdb_valid && (bus.cdb_id == 3'(mq[k2].id));
                exp_rdy = mq[k2].rdy || hit;
                checks++; if (bus.qry2_ready !== exp_rdy || (exp_rdy && bus.qry2_val !== (hit ? bus.cdb_val : mq[k2].v))) begin
                    errors++; $display("FAIL rnd_qry2 c%0d: got %b/%h want %b", c, bus.qry2_ready, bus.qry2_val, exp_rdy); end
            end
            if (rdy_in) begin
                if (m_clear) begin
                    mq.delete(); m_tail = 0; m_clear = 0;
                end else begin
                    mis = 0;
                    if (com) begin
                        e = mq.pop_front();
                        if (e.t[1] && e.tk != e.pred) begin mis = 1; m_pc = e.alt; end
                    end
                    if (bus.cdb_valid) foreach (mq[i]) if (mq[i].id == int'(bus.cdb_id)) begin
                        mq[i].rdy = 1; mq[i].v = bus.cdb_val; mq[i].tk = bus.cdb_taken;
                    end
                    if (acc) begin
                        e.id = m_tail; e.t = bus.issue_type; e.rd = bus.issue_rd; e.v = bus.issue_val; e.rdy = bus.issue_ready;
                        e.pred = bus.issue_pred_taken; e.tk = bus.issue_pred_taken; e.alt = bus.issue_alt_pc;
                        mq.push_back(e);
                        m_tail = (m_tail + 1) % 8;
                    end
                    m_clear = mis;
                end
            end
            cyc();
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_issue_commit();
        test_full_wrap();
        test_mispredict();
        test_overlap();
        test_rdy_low();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
